// File: rtl/lcd_read_ctrl.sv
//==============================================================================
// Module      : lcd_read_ctrl
// Description : HD44780 read cycle engine (busy flag/address or data byte).
//               Optional busy-poll give-up enabled by LCD_READ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_read_ctrl #(
    parameter int unsigned T_AS      = 1,
    parameter int unsigned T_EH      = 6,
    parameter int unsigned T_REC     = 6,
    parameter int unsigned MAX_POLLS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_bf,
    output logic [6:0] rd_addr,
    output logic       rd_timeout,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic       db_oe,
    input  logic [7:0] lcd_db_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EHIGH = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] c_as_last  = 8'(T_AS - 1);
    localparam logic [7:0] c_eh_last  = 8'(T_EH - 1);
    localparam logic [7:0] c_rec_last = 8'(T_REC - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  w_cnt_limit;
    logic        w_last;
    logic        r_rs;
    logic        r_poll;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_data;
    logic        r_bf;
    logic [6:0]  r_addr;
    logic        w_bf_poll;
    logic        w_tmo;
    logic        w_repoll;

    assign rd_data = r_data;
    assign rd_bf   = r_bf;
    assign rd_addr = r_addr;

    always_comb begin
        w_cnt_limit = 8'd0;
        case (r_state)
            S_SETUP: w_cnt_limit = c_as_last;
            S_EHIGH: w_cnt_limit = c_eh_last;
            S_HOLD:  w_cnt_limit = c_rec_last;
            default: w_cnt_limit = 8'd0;
        endcase
    end

    assign w_last = (r_cnt == w_cnt_limit);

    // The busy bit sampled by this read decides whether another read follows
    assign w_bf_poll = r_poll & r_bf;
    assign w_repoll  = w_bf_poll & ~w_tmo;

`ifdef LCD_READ_TIMEOUT_EN
    localparam logic [15:0] c_poll_last = 16'(MAX_POLLS - 1);
    logic r_timeout;

    assign w_tmo      = w_bf_poll & (r_poll_cnt >= c_poll_last);
    assign rd_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE && rd_req) begin
            r_timeout <= 1'b0;
        end else if (r_state == S_HOLD && w_last && w_tmo) begin
            r_timeout <= 1'b1;
        end
    end
`else
    logic [15:0] w_unused_max_polls;

    assign w_unused_max_polls = 16'(MAX_POLLS);
    assign w_tmo              = 1'b0;
    assign rd_timeout         = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (rd_req) w_next_state = S_SETUP;
            S_SETUP: if (w_last) w_next_state = S_EHIGH;
            S_EHIGH: if (w_last) w_next_state = S_HOLD;
            S_HOLD:  if (w_last) w_next_state = w_repoll ? S_SETUP : S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = 8'd0;
        if ((r_state == S_SETUP || r_state == S_EHIGH || r_state == S_HOLD) && !w_last) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    always_comb begin
        E        = 1'b0;
        RW       = 1'b0;
        RS       = 1'b0;
        db_oe    = 1'b1;
        rd_ready = 1'b0;
        rd_valid = 1'b0;
        case (r_state)
            S_IDLE: rd_ready = 1'b1;
            S_SETUP, S_HOLD: begin
                RW    = 1'b1;
                RS    = r_rs;
                db_oe = 1'b0;
            end
            S_EHIGH: begin
                RW    = 1'b1;
                RS    = r_rs;
                db_oe = 1'b0;
                E     = 1'b1;
            end
            S_DONE:  rd_valid = 1'b1;
            default: rd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_rs       <= 1'b0;
            r_poll     <= 1'b0;
            r_poll_cnt <= 16'd0;
            r_data     <= 8'd0;
            r_bf       <= 1'b0;
            r_addr     <= 7'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        r_rs       <= rd_rs;
                        r_poll     <= rd_poll & ~rd_rs;
                        r_poll_cnt <= 16'd0;
                    end
                end
                S_EHIGH: begin
                    if (w_last) begin
                        r_data <= lcd_db_i;
                        if (!r_rs) begin
                            r_bf   <= lcd_db_i[7];
                            r_addr <= lcd_db_i[6:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (w_last && w_repoll && r_poll_cnt != 16'hFFFF) begin
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_read_ctrl.sv
//==============================================================================
// Module      : tb_lcd_read_ctrl
// Description : Directed vector bench for lcd_read_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lcd_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req = 1'b0;
    logic       rd_rs = 1'b0;
    logic       rd_poll = 1'b0;
    logic [7:0] lcd_db_i = 8'h00;
    logic       rd_ready, rd_valid, rd_bf, rd_timeout, RS, RW, E, db_oe;
    logic [7:0] rd_data;
    logic [6:0] rd_addr;

    int checks = 0;
    int failures = 0;

    lcd_read_ctrl #(
        .T_AS(1), .T_EH(6), .T_REC(6), .MAX_POLLS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_rs(rd_rs), .rd_poll(rd_poll),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_bf(rd_bf), .rd_addr(rd_addr), .rd_timeout(rd_timeout),
        .RS(RS), .RW(RW), .E(E), .db_oe(db_oe), .lcd_db_i(lcd_db_i)
    );

    always #5 clk = ~clk;

    // lcd_db_i shows 'first' for the first nfirst pulses, then 'last'
    typedef struct {
        logic       rs;
        logic       poll;
        logic [7:0] first;
        int         nfirst;
        logic [7:0] last;
        logic [7:0] exp_data;
        logic       exp_bf;
        logic [6:0] exp_addr;
        int         exp_pulses;
        logic       exp_tmo;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic poll, input logic [7:0] first,
                                input int nfirst, input logic [7:0] last,
                                input logic [7:0] exp_data, input logic exp_bf,
                                input logic [6:0] exp_addr, input int exp_pulses,
                                input logic exp_tmo);
        vec_t v;
        v.rs = rs; v.poll = poll; v.first = first; v.nfirst = nfirst; v.last = last;
        v.exp_data = exp_data; v.exp_bf = exp_bf; v.exp_addr = exp_addr;
        v.exp_pulses = exp_pulses; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   pulses, ecyc, bad, valid_at;
        logic prev_e;
        @(negedge clk);
        chk({tag, "_ready_before"}, rd_ready, 1);
        rd_req   = 1'b1;
        rd_rs    = v.rs;
        rd_poll  = v.poll;
        lcd_db_i = (v.nfirst > 0) ? v.first : v.last;
        @(posedge clk);
        #1;
        rd_req  = 1'b0;
        rd_rs   = 1'b0;
        rd_poll = 1'b0;
        pulses = 0; ecyc = 0; bad = 0; valid_at = 0; prev_e = 1'b0;
        for (int n = 1; n <= 400 && valid_at == 0; n++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                valid_at = n;
            end else begin
                if (RW !== 1'b1 || RS !== v.rs || db_oe !== 1'b0) bad++;
                if (E === 1'b1 && !prev_e) pulses++;
                if (E === 1'b1) ecyc++;
                if (E !== 1'b1 && prev_e) lcd_db_i = (pulses < v.nfirst) ? v.first : v.last;
                prev_e = (E === 1'b1);
            end
        end
        chk({tag, "_latency"}, valid_at, 13 * v.exp_pulses + 1);
        chk({tag, "_pulses"}, pulses, v.exp_pulses);
        chk({tag, "_e_cycles"}, ecyc, 6 * v.exp_pulses);
        chk({tag, "_bus_ctrl"}, bad, 0);
        chk({tag, "_data"}, rd_data, v.exp_data);
        chk({tag, "_bf"}, rd_bf, v.exp_bf);
        chk({tag, "_addr"}, rd_addr, v.exp_addr);
        chk({tag, "_timeout"}, rd_timeout, v.exp_tmo);
        chk({tag, "_done_pins"}, {E, RW, db_oe}, 3'b001);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, rd_valid, 0);
        chk({tag, "_ready_after"}, rd_ready, 1);
    endtask

    vec_t tbl[6];
    vec_t tv;
    int   ecnt;
    int   vcnt;

    initial begin
        tbl[0] = mk(1'b0, 1'b0, 8'h45, 1, 8'h45, 8'h45, 1'b0, 7'h45, 1, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 8'hC3, 1, 8'hC3, 8'hC3, 1'b0, 7'h45, 1, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 8'h9F, 1, 8'h9F, 8'h9F, 1'b1, 7'h1F, 1, 1'b0);
        tbl[3] = mk(1'b1, 1'b0, 8'h5A, 1, 8'h5A, 8'h5A, 1'b1, 7'h1F, 1, 1'b0);
        tbl[4] = mk(1'b0, 1'b1, 8'h80, 3, 8'h0A, 8'h0A, 1'b0, 7'h0A, 4, 1'b0);
        tbl[5] = mk(1'b0, 1'b1, 8'h22, 1, 8'h22, 8'h22, 1'b0, 7'h22, 1, 1'b0);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pins", {E, RW, RS, db_oe}, 4'b0001);
        chk("reset_ready", rd_ready, 1);
        chk("reset_valid", rd_valid, 0);
        chk("reset_data", rd_data, 8'h00);
        chk("reset_bf_addr", {rd_bf, rd_addr}, 8'h00);
        chk("reset_timeout", rd_timeout, 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort in the third E-high cycle
        @(negedge clk);
        rd_req = 1'b1; rd_rs = 1'b0; rd_poll = 1'b0; lcd_db_i = 8'h77;
        @(posedge clk);
        #1 rd_req = 1'b0;
        ecnt = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (E === 1'b1) ecnt++;
            if (ecnt == 3) break;
        end
        chk("abort_reach", ecnt, 3);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pins", {E, RW, db_oe}, 3'b001);
        chk("abort_valid", rd_valid, 0);
        chk("abort_data", rd_data, 8'h00);
        chk("abort_ready", rd_ready, 1);
        rst = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) vcnt++;
        end
        chk("abort_no_valid", vcnt, 0);
        run_vec(tbl[0], "post_abort");

`ifdef LCD_READ_TIMEOUT_EN
        tv = mk(1'b0, 1'b1, 8'hFF, 1000, 8'hFF, 8'hFF, 1'b1, 7'h7F, 4, 1'b1);
`else
        tv = mk(1'b0, 1'b1, 8'hFF, 4, 8'h00, 8'h00, 1'b0, 7'h00, 5, 1'b0);
`endif
        run_vec(tv, "poll_limit");
        run_vec(tbl[0], "after_limit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_read_ctrl.md
Name: lcd_read_ctrl

Overview:
HD44780 read-side engine, complementing the LCD write path on the same RS/RW/E/DB pins.
- Executes read cycles (RW=1) to fetch either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Optional mode polls the busy flag until it clears, so the write controller can gate its next command.
- Sits between the LCD pin mux and the display FSM, clocked from Sys_Clk0.

Parameters:
T_AS, 1, cycles RS/RW are stable before E rises (1..255)
T_EH, 6, cycles E is held high; data sampled on the last one (1..255)
T_REC, 6, cycles E is low after the pulse, RW still 1, before the next cycle or done (1..255)
MAX_POLLS, 4096, poll read limit; used only with LCD_READ_TIMEOUT_EN (1..65535)

Ports:
clk  in  1  system clock (Sys_Clk0)
rst  in  1  synchronous, active-low reset
rd_req  in  1  read request; accepted when rd_req & rd_ready
rd_rs  in  1  latched at accept: 0 = busy flag/address, 1 = data read
rd_poll  in  1  latched at accept: repeat busy reads until BF=0 (ignored when rd_rs=1)
rd_ready  out  1  high only in IDLE
rd_valid  out  1  one-cycle pulse, result valid
rd_data  out  8  raw sampled byte
rd_bf  out  1  busy flag from the last RS=0 read
rd_addr  out  7  address counter from the last RS=0 read
rd_timeout  out  1  poll gave up (constant 0 without the macro)
RS  out  1  LCD register select
RW  out  1  LCD read/write, 1 = read
E  out  1  LCD enable
db_oe  out  1  1 = writer may drive DB; 0 = bus released to the LCD
lcd_db_i  in  8  LCD data bus input

Behaviour:
- Reset (rst=0 at an edge, any state): state=IDLE; E=0, RW=0, RS=0, db_oe=1, rd_ready=1, rd_valid=0, rd_data=0, rd_bf=0, rd_addr=0, rd_timeout=0, counters=0. Takes effect on that edge, including mid-pulse, so E drops the next cycle. No rd_valid is produced for an aborted read.
- States: IDLE, SETUP, EHIGH, HOLD, DONE.
- IDLE: E=0, RW=0, RS=0, db_oe=1. On accept, latch rd_rs and rd_poll (poll forced to 0 if rd_rs=1), clear the poll counter, go to SETUP.
- SETUP: RW=1, RS=latched rs, db_oe=0, E=0. Lasts T_AS cycles, then EHIGH.
- EHIGH: E=1 for exactly T_EH cycles.
  - On the final EHIGH edge, register lcd_db_i into rd_data.
  - If rs=0, also rd_bf=lcd_db_i[7] and rd_addr=lcd_db_i[6:0]. If rs=1, rd_bf and rd_addr are unchanged.
  - Then HOLD.
- HOLD: E=0, RW=1, RS held, db_oe=0. Lasts T_REC cycles.
  - If poll and the sampled BF=1, increment the poll counter and go to SETUP with no rd_valid.
  - Otherwise go to DONE.
- DONE: one cycle, rd_valid=1, RW=0, db_oe=1, then IDLE.
- Single-read latency: rd_valid is high T_AS+T_EH+T_REC+1 edges after the accept edge (14 with defaults).
- Poll latency: N reads take N*(T_AS+T_EH+T_REC)+1 edges.
- rd_data, rd_bf, rd_addr and rd_timeout hold their values until overwritten by a later sample or accept. rd_timeout clears on accept.
- rd_req while not in IDLE is ignored; there is no queueing.
- Timer counters are 8 bits. The poll counter is 16 bits and saturates, never wraps.
- RS/RW never change while E=1. E is never high while db_oe=1.

Optional Feature:
LCD_READ_TIMEOUT_EN
- Defined: in poll mode, when a read returns BF=1 and the poll counter has reached MAX_POLLS-1, go to DONE instead of SETUP. That read is the MAX_POLLS-th. rd_valid=1 with rd_timeout=1 and rd_bf=1.
- Undefined: polling continues until BF=0 with no limit. The rd_timeout port remains and is tied to 0.

Test Plan:
- Reset: rst=0 for 3 cycles mid-idle -> E=0, RW=0, RS=0, db_oe=1, rd_ready=1, rd_valid=0, rd_data=8'h00.
- Busy read: lcd_db_i=8'h45, rd_req with rs=0, poll=0 ->
  - RW=1, RS=0, db_oe=0 throughout; E high exactly 6 cycles.
  - rd_valid 14 edges after accept; rd_data=8'h45, rd_bf=0, rd_addr=7'h45; rd_ready back high the next cycle.
- Data read: prior rd_bf=0, lcd_db_i=8'hC3, rs=1 ->
  - RS=1 for the whole cycle, rd_data=8'hC3, rd_bf still 0.
  - rd_poll=1 is ignored: only one E pulse.
- Poll: lcd_db_i=8'h80 for the first 3 E pulses, then 8'h0A ->
  - Exactly 4 E pulses, one rd_valid at edge 53.
  - rd_bf=0, rd_addr=7'h0A, rd_timeout=0.
- Abort: rst=0 during the 3rd EHIGH cycle ->
  - E=0 the next cycle, RW=0, db_oe=1, no rd_valid, rd_data=0.
  - A new request after reset completes normally.
- Timeout (macro defined, MAX_POLLS=4, lcd_db_i=8'hFF, poll=1) ->
  - 4 E pulses then rd_valid with rd_timeout=1, rd_bf=1.
  - Macro undefined: a 5th E pulse starts, and rd_valid follows only after lcd_db_i changes to 8'h00.
